// File: rtl/mem_bus_arbiter.sv
// Burst arbiter sharing one memory port between an I-side read refiller and a D-side read/write client.
// One burst in flight at a time, round-robin on simultaneous requests, one IDLE cycle between bursts.
`timescale 1ns/1ps
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned READ_BURST_LEN  = 8,
   parameter int unsigned WRITE_BURST_LEN = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_wready,
   output logic                  d_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_wvalid,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wlast,
   input  logic                  mem_wready
);
   localparam int unsigned MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
   localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LEN - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_e;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   owner_e                last_owner_q, last_owner_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic                  burst_end;

   // Reset favours I on the first tie by pretending D was served last
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_D;
         cnt_q        <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      we_d         = we_q;
      burst_end    = 1'b0;
      i_gnt        = 1'b0;
      i_rvalid     = 1'b0;
      i_rdata      = '0;
      i_done       = 1'b0;
      d_gnt        = 1'b0;
      d_rvalid     = 1'b0;
      d_rdata      = '0;
      d_wready     = 1'b0;
      d_done       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wvalid   = 1'b0;
      mem_wdata    = '0;
      mem_wlast    = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d = CMD;
               if (i_req && (!d_req || last_owner_q == OWN_D)) begin
                  owner_d = OWN_I;
                  addr_d  = i_addr;
                  we_d    = 1'b0;
               end else begin
                  owner_d = OWN_D;
                  addr_d  = d_addr;
                  we_d    = d_we;
               end
            end
         end
         CMD: begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = addr_q;
            if (mem_ack) begin
               state_d = we_q ? WR : RD;
               cnt_d   = '0;
            end
         end
         RD: begin
            if (owner_q == OWN_I) begin
               i_rvalid = mem_rvalid;
               i_rdata  = mem_rdata;
            end else begin
               d_rvalid = mem_rvalid;
               d_rdata  = mem_rdata;
            end
            if (mem_rvalid) begin
               if (cnt_q == RD_LAST) burst_end = 1'b1;
               else                  cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         WR: begin
            mem_wvalid = 1'b1;
            mem_wdata  = d_wdata;
            d_wready   = mem_wready;
            mem_wlast  = (cnt_q == WR_LAST);
            if (mem_wready) begin
               if (cnt_q == WR_LAST) burst_end = 1'b1;
               else                  cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         i_gnt = (owner_q == OWN_I);
         d_gnt = (owner_q == OWN_D);
      end

      // Final handshake: pulse done in the same cycle and hand the tie-break to the other side
      if (burst_end) begin
         state_d      = IDLE;
         last_owner_d = owner_q;
         cnt_d        = '0;
         i_done       = (owner_q == OWN_I);
         d_done       = (owner_q == OWN_D);
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a burst-level reference model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 8;
   localparam int unsigned WL = 8;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_gnt, i_rvalid, i_done;
   logic [DW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_rvalid, d_wready, d_done;
   logic [DW-1:0] d_rdata;
   logic          mem_req, mem_we, mem_wvalid, mem_wlast;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_wready = 1'b0;

   mem_bus_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_BURST_LEN(RL), .WRITE_BURST_LEN(WL)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wready(d_wready), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast), .mem_wready(mem_wready)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one record for the burst in flight, beats counted as plain integers
   bit            m_busy = 1'b0;
   bit            m_cmd = 1'b0;
   bit            m_owner = 1'b0;   // 0 = I, 1 = D
   bit            m_we = 1'b0;
   bit            m_last = 1'b1;    // side served most recently
   logic [AW-1:0] m_addr = '0;
   int            m_beats = 0;

   always @(negedge sys_rst_n) begin
      m_busy  = 1'b0;
      m_cmd   = 1'b0;
      m_beats = 0;
      m_last  = 1'b1;
   end

   always @(posedge sys_clk) begin
      if (sys_rst_n) begin
         if (!m_busy) begin
            if (i_req || d_req) begin
               m_owner = (i_req && d_req) ? !m_last : d_req;
               m_addr  = m_owner ? d_addr : i_addr;
               m_we    = m_owner ? d_we : 1'b0;
               m_busy  = 1'b1;
               m_cmd   = 1'b1;
            end
         end else if (m_cmd) begin
            if (mem_ack) begin
               m_cmd   = 1'b0;
               m_beats = 0;
            end
         end else if (m_we ? mem_wready : mem_rvalid) begin
            m_beats++;
            if (m_beats == int'(m_we ? WL : RL)) begin
               m_busy = 1'b0;
               m_last = m_owner;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge sys_clk) begin
      bit         data_ph, last_beat, e_hs;
      logic [10:0] e_ctl, a_ctl;
      data_ph   = m_busy && !m_cmd;
      last_beat = (m_beats == int'(m_we ? WL : RL) - 1);
      e_hs      = data_ph && (m_we ? mem_wready : mem_rvalid);
      e_ctl = {m_busy && !m_owner,
               data_ph && !m_we && !m_owner && mem_rvalid,
               e_hs && last_beat && !m_owner,
               m_busy && m_owner,
               data_ph && !m_we && m_owner && mem_rvalid,
               data_ph && m_we && mem_wready,
               e_hs && last_beat && m_owner,
               m_busy && m_cmd,
               m_busy && m_cmd && m_we,
               data_ph && m_we,
               data_ph && m_we && last_beat};
      a_ctl = {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wready, d_done,
               mem_req, mem_we, mem_wvalid, mem_wlast};
      chk("model_ctl", 64'(a_ctl), 64'(e_ctl));
      if (e_ctl[9]) chk("model_i_rdata", 64'(i_rdata), 64'(mem_rdata));
      if (e_ctl[6]) chk("model_d_rdata", 64'(d_rdata), 64'(mem_rdata));
      if (e_ctl[3]) chk("model_mem_addr", 64'(mem_addr), 64'(m_addr));
      if (e_ctl[1]) chk("model_mem_wdata", 64'(mem_wdata), 64'(d_wdata));
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
   endtask

   // Drives a full read burst on the memory side and checks the owner sees every beat
   task automatic read_burst(input bit own_d, input string tag);
      logic [DW-1:0] dat;
      for (int k = 0; k < int'(RL); k++) begin
         dat        = DW'($urandom);
         mem_rvalid = 1'b1;
         mem_rdata  = dat;
         #1;
         chk({tag, "_rvalid"}, 64'(own_d ? d_rvalid : i_rvalid), 64'(1));
         chk({tag, "_rdata"}, 64'(own_d ? d_rdata : i_rdata), 64'(dat));
         chk({tag, "_done"}, 64'(own_d ? d_done : i_done), 64'(k == int'(RL) - 1));
         chk({tag, "_other_rvalid"}, 64'(own_d ? i_rvalid : d_rvalid), 64'(0));
         tick();
      end
      mem_rvalid = 1'b0;
   endtask

   initial begin
      int acc;
      tick();
      #1;
      chk("reset_ctl", 64'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wready, d_done,
                            mem_req, mem_we, mem_wvalid, mem_wlast}), 64'(0));
      chk("reset_mem_addr", 64'(mem_addr), 64'(0));
      do_reset();

      // I-side read alone, ack two cycles after the command appears
      i_req  = 1'b1;
      i_addr = AW'(32'h40);
      tick();
      #1;
      chk("t1_gnt", 64'(i_gnt), 64'(1));
      chk("t1_mem_req", 64'(mem_req), 64'(1));
      chk("t1_mem_addr", 64'(mem_addr), 64'(32'h40));
      chk("t1_mem_we", 64'(mem_we), 64'(0));
      i_req = 1'b0;
      tick();
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = DW'(k);
         #1;
         chk("t1_rvalid", 64'(i_rvalid), 64'(1));
         chk("t1_rdata", 64'(i_rdata), 64'(k));
         chk("t1_done", 64'(i_done), 64'(k == 8));
         chk("t1_d_side", 64'({d_gnt, d_rvalid, d_wready, d_done, d_rdata}), 64'(0));
         tick();
      end
      mem_rvalid = 1'b0;
      #1;
      chk("t1_gnt_after", 64'(i_gnt), 64'(0));
      chk("t1_model_last", 64'(m_last), 64'(0));

      // Simultaneous requests after reset: I first, D one IDLE cycle after i_done
      do_reset();
      i_req  = 1'b1;
      d_req  = 1'b1;
      d_we   = 1'b0;
      i_addr = AW'(32'h100);
      d_addr = AW'(32'h80);
      tick();
      #1;
      chk("t2_i_gnt", 64'(i_gnt), 64'(1));
      chk("t2_d_gnt", 64'(d_gnt), 64'(0));
      chk("t2_mem_addr", 64'(mem_addr), 64'(32'h100));
      i_req   = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      read_burst(1'b0, "t2_i");
      #1;
      chk("t2_idle_mem_req", 64'(mem_req), 64'(0));
      chk("t2_idle_d_gnt", 64'(d_gnt), 64'(0));
      tick();
      #1;
      chk("t2_d_mem_req", 64'(mem_req), 64'(1));
      chk("t2_d_gnt2", 64'(d_gnt), 64'(1));
      chk("t2_d_mem_addr", 64'(mem_addr), 64'(32'h80));
      d_req   = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      read_burst(1'b1, "t2_d");

      // D-side write burst with memory ready every other cycle
      d_req  = 1'b1;
      d_we   = 1'b1;
      d_addr = AW'(32'hC0);
      tick();
      #1;
      chk("t3_mem_we", 64'(mem_we), 64'(1));
      chk("t3_d_gnt", 64'(d_gnt), 64'(1));
      d_req   = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      acc = 0;
      for (int c = 0; c < 32 && acc < int'(WL); c++) begin
         mem_wready = c[0];
         d_wdata    = DW'(32'hA0 + acc);
         #1;
         chk("t3_wvalid", 64'(mem_wvalid), 64'(1));
         chk("t3_wdata", 64'(mem_wdata), 64'(32'hA0 + acc));
         chk("t3_wlast", 64'(mem_wlast), 64'(acc == int'(WL) - 1));
         chk("t3_done", 64'(d_done), 64'(c[0] && acc == int'(WL) - 1));
         if (mem_wready) acc++;
         tick();
      end
      mem_wready = 1'b0;
      chk("t3_beats", 64'(acc), 64'(8));
      #1;
      chk("t3_after", 64'({d_gnt, mem_wvalid}), 64'(0));
      d_we = 1'b0;

      // D holds its request; I arrives mid-burst and must win next
      d_req  = 1'b1;
      d_addr = AW'(32'h200);
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      i_req   = 1'b1;
      i_addr  = AW'(32'h300);
      read_burst(1'b1, "t4_d");
      tick();
      #1;
      chk("t4_i_gnt", 64'(i_gnt), 64'(1));
      chk("t4_d_gnt", 64'(d_gnt), 64'(0));
      chk("t4_mem_addr", 64'(mem_addr), 64'(32'h300));
      i_req   = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      read_burst(1'b0, "t4_i");
      tick();
      #1;
      chk("t4_d_again", 64'(d_gnt), 64'(1));
      d_req   = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      read_burst(1'b1, "t4_d2");

      // Reset during read beat 4 aborts the burst silently
      i_req  = 1'b1;
      i_addr = AW'(32'h400);
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = DW'(k);
         tick();
      end
      mem_rdata = DW'(4);
      #1;
      chk("t5_beat4", 64'(i_rvalid), 64'(1));
      sys_rst_n = 1'b0;
      #1;
      chk("t5_rst_ctl", 64'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wready, d_done,
                             mem_req, mem_we, mem_wvalid, mem_wlast}), 64'(0));
      chk("t5_rst_data", 64'(i_rdata | d_rdata | mem_wdata), 64'(0));
      chk("t5_rst_addr", 64'(mem_addr), 64'(0));
      mem_rvalid = 1'b0;
      tick();
      chk("t5_no_done", 64'(i_done), 64'(0));
      sys_rst_n = 1'b1;
      tick();
      #1;
      chk("t5_regnt", 64'(i_gnt), 64'(1));
      chk("t5_readdr", 64'(mem_addr), 64'(32'h400));
      i_req   = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      read_burst(1'b0, "t5_full");

      // Stray read beats in IDLE and CMD are dropped and not counted
      mem_rvalid = 1'b1;
      #1;
      chk("t6_idle_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
      i_req  = 1'b1;
      i_addr = AW'(32'h500);
      tick();
      #1;
      chk("t6_cmd_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
      tick();
      #1;
      chk("t6_cmd_rvalid2", 64'({i_rvalid, d_rvalid}), 64'(0));
      i_req      = 1'b0;
      mem_rvalid = 1'b0;
      mem_ack    = 1'b1;
      tick();
      mem_ack = 1'b0;
      read_burst(1'b0, "t6_i");
      chk("t6_model_last", 64'(m_last), 64'(0));

      // Randomized traffic: requesters hold until granted, memory responds at random
      for (int n = 0; n < 4000; n++) begin
         if (i_req) begin
            if (i_gnt && $urandom_range(1, 0) == 1) i_req = 1'b0;
         end else if ($urandom_range(3, 0) == 0) begin
            i_req  = 1'b1;
            i_addr = AW'($urandom);
         end
         if (d_req) begin
            if (d_gnt && $urandom_range(1, 0) == 1) d_req = 1'b0;
         end else if ($urandom_range(3, 0) == 0) begin
            d_req  = 1'b1;
            d_we   = 1'($urandom_range(1, 0));
            d_addr = AW'($urandom);
         end
         mem_ack    = ($urandom_range(2, 0) == 0);
         mem_rvalid = 1'($urandom_range(1, 0));
         mem_rdata  = DW'($urandom);
         mem_wready = 1'($urandom_range(1, 0));
         d_wdata    = DW'($urandom);
         sys_rst_n  = ($urandom_range(599, 0) != 0);
         tick();
      end

      sys_rst_n  = 1'b1;
      i_req      = 1'b0;
      d_req      = 1'b0;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_wready = 1'b0;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
